gcd_job_driver: RTL and testbench

Synthesizable initiator for the `gcd_machine` go/done handshake; it replaces the bench-side sequencing with hardware.
- Accepts operand pairs from an upstream valid/ready port.
- Drives `go`, `in1` and `in2` into the GCD engine and waits for the engine's `done` cycle.
- Captures the result and holds it on a buffered response port until the consumer takes it.
- Sits between a command source (CPU register file or FIFO) and one `gcd_machine` instance.

---
 rtl/gcd_job_driver.sv | 149 ++++++++++++++
 tb/tb_gcd_job_driver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_driver.sv
// Hardware sequencer for one gcd_machine: takes operand pairs, runs the engine, returns the result.
// Latency: a zero-operand bypass answers in 1 cycle; otherwise engine time plus 2 cycles.
// Backpressure: req_ready is low outside IDLE or while the engine is busy, so a held response stalls intake.
// Optional GCD_DRV_TIMEOUT_EN: adds a LAUNCH+WAIT cycle limit that aborts the job with rsp_err.
module gcd_job_driver #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             gcd_go,
  output logic [WIDTH-1:0] gcd_in1,
  output logic [WIDTH-1:0] gcd_in2,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err,
  output logic [15:0]      jobs_done
);

  // The counter is 16 bits wide, so the limit has to fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("gcd_job_driver: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic accept;   // pair taken this cycle
  logic bypass;   // accepted pair has a zero operand, engine skipped
  logic capture;  // engine finished, latch its result
  logic abort;    // time limit hit, return an error response
  logic expired;  // time limit reached in the current LAUNCH/WAIT cycle

  // Never accept while the engine still reports busy; this keeps jobs from overlapping.
  assign req_ready = (state == IDLE) && gcd_done;
  assign gcd_go    = (state == LAUNCH);
  assign rsp_valid = (state == RESP);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bypass    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (req_a == '0 || req_b == '0) begin
            bypass    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        // Engine acceptance takes priority over the limit so a started job is never orphaned.
        if (!gcd_done) begin
          state_nxt = WAIT;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      WAIT: begin
        // A result arriving on the limit cycle still counts as success.
        if (gcd_done) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, result and completed-job registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gcd_in1   <= '0;
      gcd_in2   <= '0;
      rsp_gcd   <= '0;
      jobs_done <= '0;
    end else begin
      if (accept) begin
        gcd_in1 <= req_a;
        gcd_in2 <= req_b;
      end
      // With one operand zero, OR yields the other one (and 0 for 0,0).
      if (bypass)  rsp_gcd <= req_a | req_b;
      if (capture) rsp_gcd <= gcd_out;
      if (abort)   rsp_gcd <= '0;
      if (rsp_valid && rsp_ready) jobs_done <= jobs_done + 16'd1;
    end
  end

`ifdef GCD_DRV_TIMEOUT_EN
  logic [15:0] cnt;
  logic        err_q;

  // cnt holds the number of LAUNCH/WAIT cycles already spent, so the limit cycle is TIMEOUT-1.
  assign expired = (cnt >= 16'(TIMEOUT - 1));
  assign rsp_err = err_q;

  // Cycle counter: cleared on entry to LAUNCH, runs through LAUNCH and WAIT.
  always_ff @(posedge clk) begin
    if (rst)                                   cnt <= '0;
    else if (accept && !bypass)                cnt <= '0;
    else if (state == LAUNCH || state == WAIT) cnt <= cnt + 16'd1;
  end

  // Error flag: set by an abort, cleared by any normal or bypass result.
  always_ff @(posedge clk) begin
    if (rst)                  err_q <= 1'b0;
    else if (abort)           err_q <= 1'b1;
    else if (bypass || capture) err_q <= 1'b0;
  end
`else
  assign expired = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_driver.sv
module tb_gcd_job_driver;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       gcd_go;
  logic [7:0] gcd_in1;
  logic [7:0] gcd_in2;
  logic       gcd_done;
  logic [7:0] gcd_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_gcd;
  logic       rsp_err;
  logic [15:0] jobs_done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_jobs = 0;

  gcd_job_driver #(.WIDTH(8), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .gcd_go(gcd_go), .gcd_in1(gcd_in1), .gcd_in2(gcd_in2),
    .gcd_done(gcd_done), .gcd_out(gcd_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
    .jobs_done(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subtractive GCD engine model; 'stuck' makes it ignore go so done stays high.
  logic       busy;
  logic [7:0] ex, ey;
  bit         stuck = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      ex   <= '0;
      ey   <= '0;
    end else if (!busy) begin
      if (gcd_go && !stuck) begin
        ex   <= gcd_in1;
        ey   <= gcd_in2;
        busy <= 1'b1;
      end
    end else if (ex == ey) begin
      busy <= 1'b0;
    end else if (ex > ey) begin
      ex <= ex - ey;
    end else begin
      ey <= ey - ex;
    end
  end

  assign gcd_done = !busy;
  assign gcd_out  = ex;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete job: accept, wait for the response, optionally hold it, then take it.
  task automatic do_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_gcd,
                        input logic exp_err, input int hold, input int exp_lat);
    int cyc;
    rsp_ready = (hold == 0);
    cyc = 0;
    while (!gcd_done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("done_before_accept", gcd_done, 1);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    tick();
    req_valid = 1'b0;
    chk("in1_reg", gcd_in1, a);
    chk("in2_reg", gcd_in2, b);
    chk("req_ready_busy", req_ready, 0);
    if (a == 0 || b == 0) chk("go_bypass", gcd_go, 0);
    else                  chk("go_launch", gcd_go, 1);
    cyc = 0;
    while (!rsp_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("rsp_valid", rsp_valid, 1);
    if (exp_lat >= 0) chk("latency", cyc, exp_lat);
    chk("rsp_gcd", rsp_gcd, exp_gcd);
    chk("rsp_err", rsp_err, exp_err);
    chk("go_in_resp", gcd_go, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_gcd", rsp_gcd, exp_gcd);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    exp_jobs++;
    chk("jobs_done", jobs_done, exp_jobs);
    chk("rsp_taken", rsp_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_go", gcd_go, 0);
    chk("rst_in1", gcd_in1, 0);
    chk("rst_in2", gcd_in2, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_gcd", rsp_gcd, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_jobs", jobs_done, 0);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", req_ready, 1);

    // gcd(20,15)=5: 2 LAUNCH cycles, 4 engine steps, result visible 6 cycles after go rises.
    do_job(8'd20, 8'd15, 8'd5, 1'b0, 0, 6);

    // Back-to-back jobs with the consumer always ready.
    do_job(8'd35, 8'd14, 8'd7, 1'b0, 0, -1);
    do_job(8'd48, 8'd18, 8'd6, 1'b0, 0, -1);

    // Zero-operand bypass: answer on the cycle after accept, engine untouched.
    do_job(8'd0,  8'd9,  8'd9,  1'b0, 0, 0);
    do_job(8'd0,  8'd0,  8'd0,  1'b0, 0, 0);
    do_job(8'd12, 8'd0,  8'd12, 1'b0, 0, 0);

    // Consumer stalls for 10 cycles; response must stay frozen.
    do_job(8'd35, 8'd14, 8'd7, 1'b0, 10, -1);

    // Engine that never accepts a job.
    stuck = 1'b1;
`ifdef GCD_DRV_TIMEOUT_EN
    do_job(8'd20, 8'd15, 8'd0, 1'b1, 0, 20);
    // A normal job afterwards must clear the error flag.
    stuck = 1'b0;
    do_job(8'd9, 8'd6, 8'd3, 1'b0, 0, -1);
`else
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a = 8'd20;
    req_b = 8'd15;
    tick();
    req_valid = 1'b0;
    repeat (40) tick();
    chk("no_tmo_go", gcd_go, 1);
    chk("no_tmo_valid", rsp_valid, 0);
    chk("no_tmo_err", rsp_err, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("no_tmo_rst_go", gcd_go, 0);
    exp_jobs = 0;
    stuck = 1'b0;
`endif

    // Reset in the middle of WAIT.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a = 8'd20;
    req_b = 8'd15;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("mid_wait_go", gcd_go, 0);
    chk("mid_wait_busy", gcd_done, 0);
    rst = 1'b1;
    tick();
    chk("rst_wait_go", gcd_go, 0);
    chk("rst_wait_valid", rsp_valid, 0);
    chk("rst_wait_jobs", jobs_done, 0);
    chk("rst_wait_in1", gcd_in1, 0);
    rst = 1'b0;
    exp_jobs = 0;
    tick();
    do_job(8'd20, 8'd15, 8'd5, 1'b0, 0, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
